// File: rtl/alu_instr_encoder.sv
// Encodes ALU/LW/SW commands into RV32I words and queues them for a valid/ready consumer.
// One-cycle latency into an empty queue; cmd_ready drops while the queue is full, and illegal commands are consumed and flagged on err.

module alu_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module alu_instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_kind,
  input  logic [2:0]               cmd_alu_ctrl,
  input  logic [4:0]               cmd_rd,
  input  logic [4:0]               cmd_rs1,
  input  logic [4:0]               cmd_rs2,
  input  logic [11:0]              cmd_imm,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);
  localparam logic [1:0] KIND_R  = 2'b00;
  localparam logic [1:0] KIND_I  = 2'b01;
  localparam logic [1:0] KIND_LW = 2'b10;
  localparam logic [1:0] KIND_SW = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        ctrl_ok;
  logic        illegal;
  logic [31:0] word;
  logic        accept;
  logic        full;
  logic        empty;
  logic [31:0] head;

  always_comb begin
    funct3  = 3'b000;
    funct7  = 7'b0000000;
    ctrl_ok = 1'b1;
    case (cmd_alu_ctrl)
      ALU_ADD: funct3 = 3'b000;
      ALU_SUB: begin
        funct3 = 3'b000;
        funct7 = 7'b0100000;
      end
      ALU_AND: funct3 = 3'b111;
      ALU_OR:  funct3 = 3'b110;
      ALU_SLT: funct3 = 3'b010;
      default: ctrl_ok = 1'b0;
    endcase

    // I-type has no subtract form; memory ops only carry the address add.
    illegal = !ctrl_ok
           || (cmd_kind == KIND_I && cmd_alu_ctrl == ALU_SUB)
           || (cmd_kind[1] && cmd_alu_ctrl != ALU_ADD);

    word = '0;
    case (cmd_kind)
      KIND_R:  word = {funct7, cmd_rs2, cmd_rs1, funct3, cmd_rd, OP_R};
      KIND_I:  word = {cmd_imm, cmd_rs1, funct3, cmd_rd, OP_I};
      KIND_LW: word = {cmd_imm, cmd_rs1, 3'b010, cmd_rd, OP_LW};
      KIND_SW: word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], OP_SW};
      default: word = '0;
    endcase
  end

  assign cmd_ready   = !full;
  assign accept      = cmd_valid && cmd_ready;
  assign instr_valid = !empty;
  assign instr       = empty ? 32'h0 : head;

  alu_fifo #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept && !illegal),
    .wdata (word),
    .pop   (instr_ready),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= accept && illegal;
  end
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Randomised and directed bench for alu_instr_encoder against a queue-based reference model.
module tb_alu_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 35 + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_kind = '0;
  logic [2:0]    cmd_alu_ctrl = '0;
  logic [4:0]    cmd_rd = '0;
  logic [4:0]    cmd_rs1 = '0;
  logic [4:0]    cmd_rs2 = '0;
  logic [11:0]   cmd_imm = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic          err;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  alu_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_kind     (cmd_kind),
    .cmd_alu_ctrl (cmd_alu_ctrl),
    .cmd_rd       (cmd_rd),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_imm      (cmd_imm),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .err          (err),
    .count        (count)
  );

  // Reference encoder: assembles the word field by field with shifts.
  function automatic logic [31:0] ref_encode(input logic [1:0] kind, input logic [2:0] ctrl,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [11:0] imm, output bit legal);
    logic [31:0] f3, f7, d, s1, s2, im;
    legal = 1'b1;
    f3 = 0;
    f7 = (ctrl == 3'd1) ? 32'd32 : 32'd0;
    case (ctrl)
      3'd0, 3'd1: f3 = 0;
      3'd2:       f3 = 7;
      3'd3:       f3 = 6;
      3'd5:       f3 = 2;
      default:    legal = 1'b0;
    endcase
    if (kind == 2'd1 && ctrl == 3'd1) legal = 1'b0;
    if (kind >= 2'd2 && ctrl != 3'd0) legal = 1'b0;
    d = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2); im = 32'(imm);
    case (kind)
      2'd0:    return (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h33;
      2'd1:    return (im << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
      2'd2:    return (im << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
      default: return ((im >> 5) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                      | ((im & 32'd31) << 7) | 32'h23;
    endcase
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [31:0] head;
    head = (mq.size() > 0) ? mq[0] : 32'h0;
    return {mq.size() < DEPTH, mq.size() > 0, head, exp_err, CW'(mq.size())};
  endfunction

  task automatic set_cmd(input logic [1:0] k, input logic [2:0] c, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im);
    cmd_kind = k; cmd_alu_ctrl = c; cmd_rd = d; cmd_rs1 = s1; cmd_rs2 = s2; cmd_imm = im;
  endtask

  task automatic rand_legal_cmd();
    logic [2:0] c;
    logic [1:0] k;
    k = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0: c = 3'd0; 1: c = 3'd1; 2: c = 3'd2; 3: c = 3'd3; default: c = 3'd5;
    endcase
    if (k >= 2'd2 || (k == 2'd1 && c == 3'd1)) c = 3'd0;
    set_cmd(k, c, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs and model state.
  task automatic step();
    bit acc, pop, legal;
    logic [31:0] w;
    w   = ref_encode(cmd_kind, cmd_alu_ctrl, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, legal);
    acc = cmd_valid && (mq.size() < DEPTH);
    pop = instr_ready && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (acc && legal) mq.push_back(w);
    exp_err = acc && !legal;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); exp_err = 1'b0;
    checks++;
    if ({cmd_ready, instr_valid, instr, err, count} !== {1'b1, 1'b0, 32'h0, 1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL reset_values got %h want %h", {cmd_ready, instr_valid, instr, err, count},
               {1'b1, 1'b0, 32'h0, 1'b0, CW'(0)});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({cmd_ready, instr_valid, instr, err, count} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got %h want %h", {cmd_ready, instr_valid, instr, err, count}, exp_vec());
    end
  endtask

  task automatic test_rtype();
    instr_ready = 1'b0; cmd_valid = 1'b1;
    set_cmd(2'd0, 3'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    step();
    checks++;
    if (instr !== 32'h002081B3 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL rtype_add got %h/%b want 002081b3/1", instr, instr_valid);
    end
    set_cmd(2'd0, 3'd1, 5'd5, 5'd6, 5'd7, 12'd0);
    instr_ready = 1'b1;
    step();
    checks++;
    if (instr !== 32'h407302B3 || count !== CW'(1)) begin
      errors++;
      $display("FAIL rtype_sub got %h/%0d want 407302b3/1", instr, count);
    end
    cmd_valid = 1'b0;
    step();
    checks++;
    if ({cmd_ready, instr_valid, instr, err, count} !== exp_vec()) begin
      errors++;
      $display("FAIL rtype_drain got %h want %h", {cmd_ready, instr_valid, instr, err, count}, exp_vec());
    end
  endtask

  task automatic test_mem();
    instr_ready = 1'b0; cmd_valid = 1'b1;
    set_cmd(2'd2, 3'd0, 5'd4, 5'd2, 5'd0, 12'd8);
    step();
    checks++;
    if (instr !== 32'h00812203) begin
      errors++;
      $display("FAIL mem_lw got %h want 00812203", instr);
    end
    set_cmd(2'd3, 3'd0, 5'd0, 5'd2, 5'd5, 12'd12);
    instr_ready = 1'b1;
    step();
    checks++;
    if (instr !== 32'h00512623) begin
      errors++;
      $display("FAIL mem_sw got %h want 00512623", instr);
    end
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    instr_ready = 1'b0; cmd_valid = 1'b1;
    set_cmd(2'd1, 3'd1, 5'd1, 5'd1, 5'd1, 12'd1);
    step();
    checks++;
    if (err !== 1'b1 || count !== CW'(0) || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_isub got err=%b count=%0d rdy=%b want 1/0/1", err, count, cmd_ready);
    end
    set_cmd(2'd0, 3'd6, 5'd1, 5'd1, 5'd1, 12'd1);
    step();
    checks++;
    if (err !== 1'b1 || count !== CW'(0) || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ctrl6 got err=%b count=%0d rdy=%b want 1/0/1", err, count, cmd_ready);
    end
    cmd_valid = 1'b0;
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err_clear got %b want 0", err);
    end
  endtask

  task automatic test_full();
    instr_ready = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_cmd(2'd1, 3'd0, 5'(i + 1), 5'(i), 5'd0, 12'(i * 3));
      step();
    end
    checks++;
    if (count !== CW'(DEPTH) || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_reached got count=%0d rdy=%b want %0d/0", count, cmd_ready, DEPTH);
    end
    set_cmd(2'd0, 3'd5, 5'd9, 5'd8, 5'd7, 12'd0);
    step();
    checks++;
    if ({cmd_ready, instr_valid, instr, err, count} !== exp_vec()) begin
      errors++;
      $display("FAIL full_stall got %h want %h", {cmd_ready, instr_valid, instr, err, count}, exp_vec());
    end
    instr_ready = 1'b1;
    step();
    checks++;
    if (count !== CW'(DEPTH - 1) || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop got count=%0d rdy=%b want %0d/1", count, cmd_ready, DEPTH - 1);
    end
    instr_ready = 1'b0;
    step();
    cmd_valid = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      checks++;
      if ({cmd_ready, instr_valid, instr, err, count} !== exp_vec()) begin
        errors++;
        $display("FAIL full_order[%0d] got %h want %h", i, {cmd_ready, instr_valid, instr, err, count}, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_push_pop_wrap();
    instr_ready = 1'b0; cmd_valid = 1'b1;
    repeat (2) begin
      rand_legal_cmd();
      step();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_legal_cmd();
      step();
      checks++;
      if (count !== CW'(2) || {cmd_ready, instr_valid, instr, err, count} !== exp_vec()) begin
        errors++;
        $display("FAIL wrap[%0d] got %h want %h", i, {cmd_ready, instr_valid, instr, err, count}, exp_vec());
      end
    end
    cmd_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cmd_valid   = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0)
        set_cmd(2'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
      else
        rand_legal_cmd();
      step();
      checks++;
      if ({cmd_ready, instr_valid, instr, err, count} !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d] got %h want %h", i, {cmd_ready, instr_valid, instr, err, count}, exp_vec());
      end
    end
    cmd_valid = 1'b0; instr_ready = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0; cmd_valid = 1'b1;
    repeat (3) begin
      rand_legal_cmd();
      step();
    end
    set_cmd(2'd2, 3'd3, 5'd1, 5'd1, 5'd1, 12'd1);
    step();
    checks++;
    if (count !== CW'(3) || err !== 1'b1) begin
      errors++;
      $display("FAIL mid_prefill got count=%0d err=%b want 3/1", count, err);
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    mq.delete(); exp_err = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || count !== CW'(0) || instr !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b count=%0d instr=%h err=%b want 0/0/0/0", instr_valid, count, instr, err);
    end
    #1;
    rst = 1'b0;
    cmd_valid = 1'b1;
    set_cmd(2'd2, 3'd0, 5'd4, 5'd2, 5'd0, 12'd8);
    step();
    checks++;
    if (instr !== 32'h00812203 || instr_valid !== 1'b1 || count !== CW'(1)) begin
      errors++;
      $display("FAIL mid_after got %h/%b/%0d want 00812203/1/1", instr, instr_valid, count);
    end
    cmd_valid = 1'b0; instr_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_illegal();
    test_full();
    test_push_pop_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
